// File: rtl/bypass_cmd_dispatcher.sv
// bypass_cmd_dispatcher: decodes BRAM-port slot writes into NUM_CH FWFT command FIFOs with status readback and flush.
// Define BYPASS_CMD_DROP_CNT_EN to build the per-channel 16-bit saturating drop counters.
module bypass_cmd_dispatcher #(
    parameter int NUM_CH     = 6,
    parameter int CMD_W      = 160,
    parameter int FIFO_DEPTH = 4,
    parameter int SLOT_BASE  = 2
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_aresetn,
    input  logic                    bram_en_a,
    input  logic                    bram_we_a,
    input  logic [15:0]             bram_addr_a,
    input  logic [511:0]            bram_wrdata_a,
    output logic [511:0]            bram_rddata_a,
    output logic [NUM_CH-1:0]       m_cmd_valid,
    input  logic [NUM_CH-1:0]       m_cmd_ready,
    output logic [NUM_CH*CMD_W-1:0] m_cmd_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    logic [5:0]          slot;
    logic                wr;
    logic                rd;
    logic [NUM_CH-1:0]   full;
    logic [8*NUM_CH-1:0] occ_bus;
    logic [511:0]        rd_mux;
    logic                unused_bits;

    assign slot        = bram_addr_a[11:6];
    assign wr          = bram_en_a && bram_we_a;
    assign rd          = bram_en_a && !bram_we_a;
    assign unused_bits = ^{bram_addr_a[15:12], bram_addr_a[5:0], bram_wrdata_a};

`ifdef BYPASS_CMD_DROP_CNT_EN
    logic [16*NUM_CH-1:0] drop_bus;
    logic                 clr;
    assign clr = wr && slot == 6'd0 && bram_wrdata_a[0];
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CMD_W-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]    wptr;
        logic [AW-1:0]    rptr;
        logic [OW-1:0]    occ;
        logic             push;
        logic             flush;
        logic             pop;
        logic             accept;

        assign push    = wr && slot == 6'(SLOT_BASE + c);
        assign flush   = wr && slot == 6'd1 && bram_wrdata_a[c];
        assign pop     = m_cmd_valid[c] && m_cmd_ready[c];
        assign full[c] = occ == OW'(FIFO_DEPTH);
        // a pop in the same cycle frees the slot a full-FIFO push needs
        assign accept  = push && !flush && (!full[c] || pop);

        assign m_cmd_valid[c]                = occ != '0;
        assign m_cmd_data[c*CMD_W +: CMD_W]  = mem[rptr];
        assign occ_bus[8*c +: 8]             = 8'(occ);

        always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
            if (!pcie_aresetn) begin
                wptr <= '0;
                rptr <= '0;
                occ  <= '0;
            end else if (flush) begin
                wptr <= '0;
                rptr <= '0;
                occ  <= '0;
            end else begin
                wptr <= accept ? wptr + 1'b1 : wptr;
                rptr <= pop ? rptr + 1'b1 : rptr;
                occ  <= occ + OW'(accept) - OW'(pop);
            end
        end

        always_ff @(posedge pcie_clk) begin
            if (accept)
                mem[wptr] <= bram_wrdata_a[CMD_W-1:0];
        end

`ifdef BYPASS_CMD_DROP_CNT_EN
        logic [15:0] drop_cnt;
        logic        drop;

        assign drop = push && !flush && full[c] && !pop;
        assign drop_bus[16*c +: 16] = drop_cnt;

        always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
            if (!pcie_aresetn)
                drop_cnt <= '0;
            else if (clr)
                drop_cnt <= '0;
            else if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
`endif
    end

    always_comb begin
        rd_mux = '0;
        if (slot == 6'd0) begin
            rd_mux[8*NUM_CH-1:0] = occ_bus;
`ifdef BYPASS_CMD_DROP_CNT_EN
            rd_mux[256 +: 16*NUM_CH] = drop_bus;
`endif
        end else if (slot == 6'd1) begin
            rd_mux[NUM_CH-1:0]   = full;
            rd_mux[16 +: NUM_CH] = m_cmd_valid;
        end
    end

    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn)
            bram_rddata_a <= '0;
        else if (rd)
            bram_rddata_a <= rd_mux;
    end
endmodule

// File: tb/tb_bypass_cmd_dispatcher.sv
// tb_bypass_cmd_dispatcher: directed scoreboard bench for bypass_cmd_dispatcher.
// Per-channel queues model the FIFOs; drop counts are expected only when BYPASS_CMD_DROP_CNT_EN is defined.
module tb_bypass_cmd_dispatcher;
    localparam int NUM_CH = 6;
    localparam int CMD_W  = 160;
    localparam int DEPTH  = 4;
    localparam int BASE   = 2;

    logic                    clk = 0;
    logic                    rst_n = 0;
    logic                    en = 0;
    logic                    we = 0;
    logic [15:0]             addr = 0;
    logic [511:0]            wdata = 0;
    logic [511:0]            rdata;
    logic [NUM_CH-1:0]       valid;
    logic [NUM_CH-1:0]       ready = 0;
    logic [NUM_CH*CMD_W-1:0] data;

    int checks = 0;
    int errors = 0;

    logic [CMD_W-1:0] exp_q [NUM_CH][$];
    int               mdrop [NUM_CH];

    bypass_cmd_dispatcher #(.NUM_CH(NUM_CH), .CMD_W(CMD_W), .FIFO_DEPTH(DEPTH), .SLOT_BASE(BASE)) dut (
        .pcie_clk(clk), .pcie_aresetn(rst_n), .bram_en_a(en), .bram_we_a(we),
        .bram_addr_a(addr), .bram_wrdata_a(wdata), .bram_rddata_a(rdata),
        .m_cmd_valid(valid), .m_cmd_ready(ready), .m_cmd_data(data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] slot_addr(input int s);
        return {4'd0, 6'(s), 6'($urandom_range(0, 63))};
    endfunction

    function automatic logic [511:0] exp_stat0();
        logic [511:0] r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            r[8*c +: 8] = 8'(exp_q[c].size());
`ifdef BYPASS_CMD_DROP_CNT_EN
            r[256+16*c +: 16] = 16'(mdrop[c]);
`endif
        end
        return r;
    endfunction

    function automatic logic [511:0] exp_stat1();
        logic [511:0] r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c]    = exp_q[c].size() == DEPTH;
            r[16+c] = exp_q[c].size() != 0;
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_valid();
        logic [NUM_CH-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c] = exp_q[c].size() != 0;
        return v;
    endfunction

    function automatic void model_push(input int c, input logic [CMD_W-1:0] d);
        if (exp_q[c].size() < DEPTH) exp_q[c].push_back(d);
        else if (mdrop[c] < 65535) mdrop[c]++;
    endfunction

    // all tasks start and end just after a falling edge
    task automatic write(input int s, input logic [511:0] d);
        en = 1; we = 1; addr = slot_addr(s); wdata = d;
        if (s >= BASE && s < BASE + NUM_CH) model_push(s - BASE, d[CMD_W-1:0]);
        @(negedge clk);
        en = 0; we = 0;
    endtask

    task automatic read(input int s, output logic [511:0] d);
        en = 1; we = 0; addr = slot_addr(s);
        @(negedge clk);
        en = 0;
        d = rdata;
    endtask

    task automatic pop_chk(input int c);
        logic [CMD_W-1:0] e;
        e = exp_q[c].pop_front();
        check("pop_valid", 512'(valid[c]), 512'(1));
        check("pop_data", 512'(data[c*CMD_W +: CMD_W]), 512'(e));
        ready[c] = 1;
        @(negedge clk);
        ready[c] = 0;
    endtask

    logic [511:0]     rd;
    logic [CMD_W-1:0] v;

    initial begin
        for (int c = 0; c < NUM_CH; c++) mdrop[c] = 0;
        #12;
        check("rst_valid", 512'(valid), 512'(0));
        check("rst_rdata", rdata, '0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        write(3, 512'hABCD);
        check("ch1_valid", 512'(valid), 512'(exp_valid()));
        check("ch1_data", 512'(data[1*CMD_W +: CMD_W]), 512'hABCD);
        repeat (2) @(negedge clk);
        check("ch1_hold", 512'(data[1*CMD_W +: CMD_W]), 512'hABCD);

        for (int i = 1; i <= 5; i++) write(2, 512'(i));
        read(0, rd);
        check("ovf_stat0", rd, exp_stat0());
        read(1, rd);
        check("ovf_stat1", rd, exp_stat1());

        // full channel with pop and push in the same cycle
        check("full_head", 512'(data[0 +: CMD_W]), 512'(exp_q[0][0]));
        ready[0] = 1;
        write(2, 512'h6);
        ready[0] = 0;
        void'(exp_q[0].pop_front());
        exp_q[0].push_back(CMD_W'(6));
        read(0, rd);
        check("popush_stat0", rd, exp_stat0());
        for (int i = 0; i < 4; i++) pop_chk(0);
        check("ch0_empty", 512'(valid[0]), 512'(0));

        write(9, 512'h1234);
        check("ignored_slot", 512'(valid), 512'(exp_valid()));
        read(9, rd);
        check("rd_other", rd, '0);

        // back-to-back writes to channel 5
        en = 1; we = 1;
        for (int i = 0; i < 3; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom, $urandom};
            addr = slot_addr(BASE + 5); wdata = 512'(v);
            model_push(5, v);
            @(negedge clk);
        end
        en = 0; we = 0;
        for (int i = 0; i < 3; i++) pop_chk(5);

        // flush channels 0 and 2 with a pop on channel 0 in the flush cycle
        write(2, 512'h7);
        write(2, 512'h8);
        write(4, 512'h9);
        check("flush_head", 512'(data[0 +: CMD_W]), 512'h7);
        ready[0] = 1;
        write(1, 512'h05);
        ready[0] = 0;
        exp_q[0].delete();
        exp_q[2].delete();
        check("flush_valid", 512'(valid), 512'(exp_valid()));
        read(0, rd);
        check("flush_stat0", rd, exp_stat0());

        write(0, 512'h1);
`ifdef BYPASS_CMD_DROP_CNT_EN
        for (int c = 0; c < NUM_CH; c++) mdrop[c] = 0;
`endif
        read(0, rd);
        check("clr_stat0", rd, exp_stat0());

        // asynchronous reset with entries in flight
        for (int i = 0; i < 3; i++) write(5, 512'(20 + i));
        check("pre_rst_valid", 512'(valid), 512'(exp_valid()));
        #2 rst_n = 0;
        #1 check("async_valid", 512'(valid), 512'(0));
        check("async_rdata", rdata, '0);
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q[c].delete();
            mdrop[c] = 0;
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        read(0, rd);
        check("post_rst_stat0", rd, '0);
        read(1, rd);
        check("post_rst_stat1", rd, exp_stat1());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
